// File: rtl/turbo_pkg.sv
// Shared turbo-encoder constants: trellis generators (13/15 octal), tail length,
// default BPSK amplitude and the constituent-encoder FSM state type.
package turbo_pkg;

  localparam logic [3:0] G_FB = 4'o13;
  localparam logic [3:0] G_FF = 4'o15;
  // Tap masks over s[2:0], where s[0] is the most recent register (delay 1).
  localparam logic [2:0] FB_MASK = {G_FB[0], G_FB[1], G_FB[2]};
  localparam logic [2:0] FF_MASK = {G_FF[0], G_FF[1], G_FF[2]};

  localparam int TAIL_LEN    = 3;
  localparam int AMP_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of the 13/15 RSC trellis. With tail_i set the input is
// replaced by the feedback value so the recursion bit a is forced to zero.
module rsc_trellis_step
  import turbo_pkg::*;
(
  input  logic       u_i,
  input  logic [2:0] s_i,
  input  logic       tail_i,
  output logic       u_eff_o,
  output logic       a_o,
  output logic       z_o,
  output logic [2:0] s_next_o
);

  logic fb;

  always_comb begin
    fb       = ^(s_i & FB_MASK);
    u_eff_o  = tail_i ? fb : u_i;
    a_o      = u_eff_o ^ fb;
    z_o      = a_o ^ (^(s_i & FF_MASK));
    s_next_o = {s_i[1:0], a_o};
  end

endmodule

// File: rtl/rsc_tail_encoder.sv
// Streaming RSC constituent encoder: K data samples followed by 3 termination samples.
// Define SOFT_MAP_EN for +/-AMP BPSK samples; otherwise samples are hard bits {15'b0, bit}.
module rsc_tail_encoder
  import turbo_pkg::*;
#(
  parameter int K     = 40,
  parameter int CNT_W = 13,
  parameter int AMP   = AMP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sys_o,
  output logic [15:0] par_o,
  output logic        out_tail,
  output logic        out_last,
  output logic        busy,
  output state_e      dbg_state_o
);

  localparam logic [CNT_W-1:0] K_M1      = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] TAIL_M1   = CNT_W'(TAIL_LEN - 1);
  localparam logic             PARAMS_OK = (K >= 1) && (K - 1 < 2**CNT_W) && (AMP > 0) && (AMP < 32768);

`ifdef SOFT_MAP_EN
  localparam logic [15:0] AMP_POS = 16'(AMP);
  localparam logic [15:0] AMP_NEG = 16'(-AMP);
`endif

  function automatic logic [15:0] to_sample(input logic b);
`ifdef SOFT_MAP_EN
    to_sample = b ? AMP_NEG : AMP_POS;
`else
    to_sample = {15'b0, b};
`endif
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [15:0]      sys_q, sys_d, par_q, par_d;
  logic             tail_q, tail_d, last_q, last_d;

  logic       step_u, step_a, step_z;
  logic [2:0] step_s;
  logic       slot_free;

  rsc_trellis_step u_step (
    .u_i      (in_bit),
    .s_i      (s_q),
    .tail_i   (state_q == TAIL),
    .u_eff_o  (step_u),
    .a_o      (step_a),
    .z_o      (step_z),
    .s_next_o (step_s)
  );

  // The output register is free when empty or being consumed this cycle.
  assign slot_free = !valid_q || out_ready;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    sys_d    = sys_q;
    par_d    = par_q;
    tail_d   = tail_q;
    last_d   = last_q;
    in_ready = 1'b0;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      tail_d  = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DATA;
          cnt_d   = '0;
          s_d     = '0;
        end
      end
      DATA: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          valid_d = 1'b1;
          sys_d   = to_sample(step_u);
          par_d   = to_sample(step_z);
          tail_d  = 1'b0;
          last_d  = 1'b0;
          s_d     = step_s;
          if (cnt_q == K_M1) begin
            state_d = TAIL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          valid_d = 1'b1;
          sys_d   = to_sample(step_u);
          par_d   = to_sample(step_z);
          tail_d  = 1'b1;
          last_d  = (cnt_q == TAIL_M1);
          s_d     = step_s;
          if (cnt_q == TAIL_M1) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sys_q   <= '0;
      par_q   <= '0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
    end
  end

  assign out_valid   = valid_q;
  assign sys_o       = sys_q;
  assign par_o       = par_q;
  assign out_tail    = tail_q;
  assign out_last    = last_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // Termination must return the trellis to zero, and tail steps must never feed back a one.
  a_params_ok : assert property (@(posedge clk) PARAMS_OK);
  a_tail_zero : assert property (@(posedge clk) disable iff (!rst_n) (state_q == DRAIN) |-> (s_q == 3'b000));
  a_tail_a0   : assert property (@(posedge clk) disable iff (!rst_n) (state_q == TAIL) |-> !step_a);

endmodule
